pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Controller that owns every write, add and count command into the CPU program counter. It arbitrates between sequential opcode/operand fetch, decoder jump requests, HALT and the 5-source interrupt dispatch. Dispatch runs as 5 steps: 2 waits, push PC high byte, push PC low byte, jump to the vector. It sits between the instruction decoder and the program counter; it also drives the stack-push port and the IF acknowledge lines.

Parameters:
NUM_IRQ, 5, number of interrupt sources (bit 0 = highest priority)
VECTOR_BASE, 16'h0040, vector address of IRQ 0
VECTOR_STRIDE, 8, address step between consecutive vectors

Ports:
clk  in  1  system clock, one edge per M-cycle step
reset  in  1  asynchronous, active-low reset (asserted when 0)
instr_boundary  in  1  decoder: current instruction completes this cycle
fetch_req  in  1  decoder consumes a byte at PC; PC must increment
jump_req  in  1  decoder requests a PC load
jump_rel  in  1  1 = relative jump, 0 = absolute jump
jump_target  in  16  absolute target
jump_offset  in  8  signed relative offset
halt_req  in  1  HALT opcode executed
ime  in  1  interrupt master enable
irq_flags  in  NUM_IRQ  IF register
irq_enable  in  NUM_IRQ  IE register
pc_value  in  16  current program counter value
pc_data  out  16  data to program counter
pc_write_enable  out  1  program counter load/add strobe
pc_write_add  out  1  1 = add, 0 = set
pc_count_enable  out  1  program counter increment
push_valid  out  1  stack push request
push_data  out  8  byte to push
push_ready  in  1  push accepted this cycle
irq_ack  out  NUM_IRQ  one-hot pulse that clears the serviced IF bit
ime_clear  out  1  pulse that clears IME
halted  out  1  core is in HALT
busy  out  1  dispatch in progress; decoder must stall

Behaviour:
- pending = irq_flags & irq_enable. Serviced index = lowest set bit, from a priority encoder.
- States: RUN, HALT, WAIT1, WAIT2, PUSH_HI, PUSH_LO, JUMP.
- Reset (asynchronous, active-low): state RUN. All outputs 0 and pc_data = 0. The latched index is cleared. Reset asserted mid-dispatch aborts with no ack and no push.
- Outputs in RUN are combinational from the inputs, so the PC updates on the same clock edge as the request. Outputs in all other states decode from the state only.
- RUN, priority order per cycle:
  - jump_req: pc_write_enable = 1, pc_write_add = jump_rel, pc_data = jump_rel ? sign-extend16(jump_offset) : jump_target. For a relative jump the resulting PC = PC + offset - 1. Any fetch_req in the same cycle is dropped.
  - fetch_req alone: pc_count_enable = 1.
- Dispatch is taken when instr_boundary and ime and pending != 0 in RUN:
  - Latch the serviced index.
  - Suppress fetch_req in that cycle. jump_req is still honoured.
  - Next state is WAIT1.
- halt_req handling in RUN (dispatch not taken):
  - pending == 0: go to HALT.
  - pending != 0: stay in RUN. The HALT bug is not modelled.
- HALT:
  - halted = 1. No count and no write. fetch_req and jump_req are ignored.
  - pending != 0 and ime: latch the index and go to WAIT1.
  - pending != 0 and not ime: go to RUN.
- WAIT1: pulse irq_ack[idx] and ime_clear for exactly 1 cycle, then go to WAIT2.
- WAIT2: 1 cycle, then go to PUSH_HI.
- PUSH_HI: push_valid = 1, push_data = pc_value[15:8]. Hold until push_ready, then go to PUSH_LO.
- PUSH_LO: push_valid = 1, push_data = pc_value[7:0]. Hold until push_ready, then go to JUMP.
- JUMP: pc_write_enable = 1, pc_write_add = 0, pc_data = VECTOR_BASE + idx*VECTOR_STRIDE (16-bit, wraps). Then go to RUN.
- busy = 1 in WAIT1 through JUMP. During dispatch, fetch_req, jump_req and halt_req are ignored and pc_count_enable = 0.
- The latched index is final. Changes to IF/IE after latching do not alter the vector, and the real-hardware cancel-to-0000 quirk is not modelled.
- An unbounded push_ready stall holds the state with outputs stable.
- Minimum dispatch is 5 cycles.

Decomposition:
- Shared package gb_cpu_pkg holds:
  - the state enum;
  - IRQ index constants: VBLANK = 0, LCD = 1, TIMER = 2, SERIAL = 3, JOYPAD = 4;
  - vector constants 0x40, 0x48, 0x50, 0x58, 0x60.
- One sub-module: irq_priority_encoder. Input: pending[NUM_IRQ]. Outputs: any, idx[2:0].

Test Plan:
- Fetch and jumps: fetch_req for 3 cycles from PC = 0x0100 -> PC = 0x0103. Then jump_req abs 0xC000 together with fetch_req -> PC = 0xC000, no count.
- Relative jump: PC = 0x0200, jump_rel, offset 0xFE -> pc_data = 0xFFFE, PC = 0x01FD.
- Dispatch: PC = 0x1234, ime = 1, IF = 0x06, IE = 0x04, instr_boundary:
  - irq_ack = 0x04 and ime_clear pulse one cycle later;
  - pushes 0x12 then 0x34;
  - PC = 0x0050;
  - busy high for exactly 5 cycles with push_ready tied 1.
- Priority and stall: IF = IE = 0x1F -> vector 0x0040, ack 0x01. Hold push_ready = 0 for 4 cycles in PUSH_HI -> state and push_data stay 0x12 with no advance.
- HALT: halt_req with pending = 0 -> halted = 1, no count.
  - Raise IF/IE bit 4 with ime = 0 -> return to RUN, no ack.
  - Repeat with ime = 1 -> dispatch to 0x0060.
- Reset abort: assert reset (drive 0) during PUSH_LO -> all outputs 0 immediately. After release: state RUN, no further push.

Source files
------------

// File: rtl/gb_cpu_pkg.sv
// rtl/gb_cpu_pkg.sv - shared types and constants for the PC sequencer
//
// Holds the sequencer state encoding, the interrupt source indices, their
// fixed vector addresses and a helper that computes a vector address from a
// base, a stride and a source index.
package gb_cpu_pkg;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_HALT,
        ST_WAIT1,
        ST_WAIT2,
        ST_PUSH_HI,
        ST_PUSH_LO,
        ST_JUMP
    } seqState_t;

    // Interrupt source indices, lowest index wins arbitration.
    localparam logic [2:0] IRQ_VBLANK = 3'd0;
    localparam logic [2:0] IRQ_LCD    = 3'd1;
    localparam logic [2:0] IRQ_TIMER  = 3'd2;
    localparam logic [2:0] IRQ_SERIAL = 3'd3;
    localparam logic [2:0] IRQ_JOYPAD = 3'd4;

    // Vector addresses with the default base and stride.
    localparam logic [15:0] VEC_VBLANK = 16'h0040;
    localparam logic [15:0] VEC_LCD    = 16'h0048;
    localparam logic [15:0] VEC_TIMER  = 16'h0050;
    localparam logic [15:0] VEC_SERIAL = 16'h0058;
    localparam logic [15:0] VEC_JOYPAD = 16'h0060;

    // Result is truncated to 16 bits, so large strides wrap.
    function automatic logic [15:0] vectorAddr(
        input logic [15:0] base,
        input logic [15:0] stride,
        input logic [2:0]  idx
    );
        return base + stride * {13'b0, idx};
    endfunction

endpackage

// File: rtl/irq_priority_encoder.sv
// rtl/irq_priority_encoder.sv - fixed-priority encoder for pending interrupts
//
// Ports:
//   pending - pending interrupt bits, bit 0 has the highest priority
//   any     - at least one bit of pending is set
//   idx     - index of the lowest set bit (0 when nothing is pending)
module irq_priority_encoder #(
    parameter int NUM_IRQ = 5
) (
    input  logic [NUM_IRQ-1:0] pending,
    output logic               any,
    output logic [2:0]         idx
);

    always_comb begin
        any = |pending;
        idx = '0;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending[i]) begin
                idx = 3'(i);
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter command sequencer with interrupt dispatch
//
// Owns every set/add/increment command into the program counter. Arbitrates
// sequential fetch, decoder jumps, HALT and the interrupt dispatch sequence
// WAIT1 -> WAIT2 -> PUSH_HI -> PUSH_LO -> JUMP.
//
// Ports:
//   clk, reset            - clock, asynchronous active-low reset
//   instr_boundary        - current instruction completes this cycle
//   fetch_req             - decoder consumes a byte, PC must increment
//   jump_req, jump_rel    - PC load request, relative (1) or absolute (0)
//   jump_target           - absolute jump target
//   jump_offset           - signed relative offset
//   halt_req              - HALT opcode executed
//   ime                   - interrupt master enable
//   irq_flags, irq_enable - IF and IE registers
//   pc_value              - current program counter value
//   pc_data               - data to the program counter
//   pc_write_enable       - program counter load/add strobe
//   pc_write_add          - 1 = add pc_data, 0 = set to pc_data
//   pc_count_enable       - program counter increment
//   push_valid, push_data - stack push request and byte
//   push_ready            - push accepted this cycle
//   irq_ack               - one-hot pulse clearing the serviced IF bit
//   ime_clear             - pulse clearing IME
//   halted                - core is in HALT
//   busy                  - dispatch in progress, decoder must stall
module pc_sequencer
    import gb_cpu_pkg::*;
#(
    parameter int          NUM_IRQ       = 5,
    parameter logic [15:0] VECTOR_BASE   = 16'h0040,
    parameter int          VECTOR_STRIDE = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               instr_boundary,
    input  logic               fetch_req,
    input  logic               jump_req,
    input  logic               jump_rel,
    input  logic [15:0]        jump_target,
    input  logic [7:0]         jump_offset,
    input  logic               halt_req,
    input  logic               ime,
    input  logic [NUM_IRQ-1:0] irq_flags,
    input  logic [NUM_IRQ-1:0] irq_enable,
    input  logic [15:0]        pc_value,
    output logic [15:0]        pc_data,
    output logic               pc_write_enable,
    output logic               pc_write_add,
    output logic               pc_count_enable,
    output logic               push_valid,
    output logic [7:0]         push_data,
    input  logic               push_ready,
    output logic [NUM_IRQ-1:0] irq_ack,
    output logic               ime_clear,
    output logic               halted,
    output logic               busy
);

    logic [NUM_IRQ-1:0] pending;
    logic               irqAny;
    logic [2:0]         irqIdx;
    seqState_t          state;
    logic [2:0]         idxQ;
    logic               takeDispatch;

    assign pending = irq_flags & irq_enable;

    irq_priority_encoder #(
        .NUM_IRQ (NUM_IRQ)
    ) uPrio (
        .pending (pending),
        .any     (irqAny),
        .idx     (irqIdx)
    );

    assign takeDispatch = (state == ST_RUN) && instr_boundary && ime && irqAny;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_RUN;
            idxQ  <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (takeDispatch) begin
                        idxQ  <= irqIdx;
                        state <= ST_WAIT1;
                    end else if (halt_req && !irqAny) begin
                        // With an interrupt already pending HALT falls
                        // straight through and execution continues.
                        state <= ST_HALT;
                    end
                end
                ST_HALT: begin
                    if (irqAny) begin
                        if (ime) begin
                            idxQ  <= irqIdx;
                            state <= ST_WAIT1;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_WAIT1:   state <= ST_WAIT2;
                ST_WAIT2:   state <= ST_PUSH_HI;
                ST_PUSH_HI: if (push_ready) state <= ST_PUSH_LO;
                ST_PUSH_LO: if (push_ready) state <= ST_JUMP;
                ST_JUMP:    state <= ST_RUN;
                default:    state <= ST_RUN;
            endcase
        end
    end

    // RUN outputs follow the request inputs directly so the PC moves on the
    // same edge as the request; every other state decodes from the state.
    // Reset is folded in so an abort drops all strobes immediately.
    always_comb begin
        pc_data         = '0;
        pc_write_enable = 1'b0;
        pc_write_add    = 1'b0;
        pc_count_enable = 1'b0;
        push_valid      = 1'b0;
        push_data       = '0;
        irq_ack         = '0;
        ime_clear       = 1'b0;
        halted          = 1'b0;
        busy            = 1'b0;
        if (reset) begin
            case (state)
                ST_RUN: begin
                    if (jump_req) begin
                        pc_write_enable = 1'b1;
                        pc_write_add    = jump_rel;
                        pc_data         = jump_rel ? {{8{jump_offset[7]}}, jump_offset}
                                                   : jump_target;
                    end else if (fetch_req && !takeDispatch) begin
                        pc_count_enable = 1'b1;
                    end
                end
                ST_HALT: begin
                    halted = 1'b1;
                end
                ST_WAIT1: begin
                    busy      = 1'b1;
                    ime_clear = 1'b1;
                    for (int i = 0; i < NUM_IRQ; i++) begin
                        irq_ack[i] = (idxQ == 3'(i));
                    end
                end
                ST_WAIT2: begin
                    busy = 1'b1;
                end
                ST_PUSH_HI: begin
                    busy       = 1'b1;
                    push_valid = 1'b1;
                    push_data  = pc_value[15:8];
                end
                ST_PUSH_LO: begin
                    busy       = 1'b1;
                    push_valid = 1'b1;
                    push_data  = pc_value[7:0];
                end
                ST_JUMP: begin
                    busy            = 1'b1;
                    pc_write_enable = 1'b1;
                    pc_data         = vectorAddr(VECTOR_BASE, 16'(VECTOR_STRIDE), idxQ);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rstN;
    logic        instrBoundary, fetchReq, jumpReq, jumpRel, haltReq, ime, pushReady;
    logic [15:0] jumpTarget, pc;
    logic [7:0]  jumpOffset;
    logic [4:0]  irqFlags, irqEnable;
    logic [15:0] pcData;
    logic        pcWe, pcAdd, pcCnt, pushValid, imeClear, halted, busy;
    logic [7:0]  pushData;
    logic [4:0]  irqAck;

    int nCmp = 0;
    int nBad = 0;
    int busyCnt;
    logic [7:0] pushQ[$];
    logic [4:0] ackQ[$];

    typedef struct {
        logic        setPc;
        logic [15:0] pcIn;
        logic        fetch, jump, rel;
        logic [15:0] target;
        logic [7:0]  offset;
        logic        boundary, imeIn;
        logic [4:0]  flags, enables;
        logic        expWe, expAdd, expCnt;
        logic [15:0] expData, expPc;
    } vec_t;
    vec_t vecs[11];

    pc_sequencer dut (
        .clk             (clk),
        .reset           (rstN),
        .instr_boundary  (instrBoundary),
        .fetch_req       (fetchReq),
        .jump_req        (jumpReq),
        .jump_rel        (jumpRel),
        .jump_target     (jumpTarget),
        .jump_offset     (jumpOffset),
        .halt_req        (haltReq),
        .ime             (ime),
        .irq_flags       (irqFlags),
        .irq_enable      (irqEnable),
        .pc_value        (pc),
        .pc_data         (pcData),
        .pc_write_enable (pcWe),
        .pc_write_add    (pcAdd),
        .pc_count_enable (pcCnt),
        .push_valid      (pushValid),
        .push_data       (pushData),
        .push_ready      (pushReady),
        .irq_ack         (irqAck),
        .ime_clear       (imeClear),
        .halted          (halted),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock: scoreboard and PC model sample at the falling edge, the PC
    // model commits at the rising edge, inputs may change 2 units later.
    task automatic tick();
        logic [15:0] nxt;
        @(negedge clk);
        nxt = pc;
        if (pushValid && pushReady) begin
            if (pushQ.size() == 0) check("push_unexpected", 32'(pushData), 32'hDEAD);
            else check("push_data", 32'(pushData), 32'(pushQ.pop_front()));
        end
        if (irqAck != 5'd0) begin
            if (ackQ.size() == 0) check("ack_unexpected", 32'(irqAck), 32'h0);
            else check("irq_ack", 32'(irqAck), 32'(ackQ.pop_front()));
        end
        if (busy) busyCnt++;
        if (pcWe) nxt = pcAdd ? pc + pcData - 16'd1 : pcData;
        else if (pcCnt) nxt = pc + 16'd1;
        @(posedge clk);
        pc = nxt;
        #2;
    endtask

    task automatic runUntilIdle(input string name);
        for (int i = 0; i < 20 && busy; i++) tick();
        check({name, "_idle"}, 32'(busy), 32'h0);
    endtask

    task automatic clearInputs();
        instrBoundary = 0; fetchReq = 0; jumpReq = 0; jumpRel = 0; haltReq = 0;
        ime = 0; jumpTarget = 0; jumpOffset = 0; irqFlags = 0; irqEnable = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 16'h0100, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 5'h00, 5'h00, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0101};
        vecs[1]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 5'h00, 5'h00, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0102};
        vecs[2]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 5'h00, 5'h00, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0103};
        vecs[3]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'hC000, 8'h00, 1'b0, 1'b0, 5'h00, 5'h00, 1'b1, 1'b0, 1'b0, 16'hC000, 16'hC000};
        vecs[4]  = '{1'b1, 16'h0200, 1'b0, 1'b1, 1'b1, 16'h0000, 8'hFE, 1'b0, 1'b0, 5'h00, 5'h00, 1'b1, 1'b1, 1'b0, 16'hFFFE, 16'h01FD};
        vecs[5]  = '{1'b1, 16'h1000, 1'b0, 1'b1, 1'b1, 16'h0000, 8'h05, 1'b0, 1'b0, 5'h00, 5'h00, 1'b1, 1'b1, 1'b0, 16'h0005, 16'h1004};
        vecs[6]  = '{1'b1, 16'h0100, 1'b1, 1'b1, 1'b1, 16'h0000, 8'h80, 1'b0, 1'b0, 5'h00, 5'h00, 1'b1, 1'b1, 1'b0, 16'hFF80, 16'h007F};
        vecs[7]  = '{1'b1, 16'h0400, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 5'h00, 5'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0400};
        vecs[8]  = '{1'b1, 16'h0500, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 5'h01, 5'h01, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0501};
        vecs[9]  = '{1'b1, 16'h0600, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 5'h02, 5'h01, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0601};
        vecs[10] = '{1'b1, 16'h0700, 1'b0, 1'b1, 1'b0, 16'h1234, 8'hFE, 1'b0, 1'b0, 5'h00, 5'h00, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h1234};

        // Reset holds every output low even with requests present.
        clearInputs();
        rstN = 0; pushReady = 1; pc = 16'h0000; busyCnt = 0;
        fetchReq = 1; jumpReq = 1; jumpTarget = 16'hBEEF;
        @(posedge clk); #2;
        check("rst_we", 32'(pcWe), 32'h0);
        check("rst_cnt", 32'(pcCnt), 32'h0);
        check("rst_data", 32'(pcData), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        rstN = 1;
        clearInputs();
        tick();

        // RUN-state vector table.
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].setPc) pc = vecs[i].pcIn;
            fetchReq = vecs[i].fetch; jumpReq = vecs[i].jump; jumpRel = vecs[i].rel;
            jumpTarget = vecs[i].target; jumpOffset = vecs[i].offset;
            instrBoundary = vecs[i].boundary; ime = vecs[i].imeIn;
            irqFlags = vecs[i].flags; irqEnable = vecs[i].enables;
            #1;
            check($sformatf("v%0d_we", i), 32'(pcWe), 32'(vecs[i].expWe));
            check($sformatf("v%0d_add", i), 32'(pcAdd), 32'(vecs[i].expAdd));
            check($sformatf("v%0d_cnt", i), 32'(pcCnt), 32'(vecs[i].expCnt));
            check($sformatf("v%0d_data", i), 32'(pcData), 32'(vecs[i].expData));
            tick();
            check($sformatf("v%0d_pc", i), 32'(pc), 32'(vecs[i].expPc));
            check($sformatf("v%0d_busy", i), 32'(busy), 32'h0);
        end
        clearInputs();

        // Dispatch of TIMER: ack one cycle later, two pushes, vector 0x0050.
        pc = 16'h1234; irqFlags = 5'h06; irqEnable = 5'h04; ime = 1;
        instrBoundary = 1; fetchReq = 1; pushReady = 1;
        #1;
        check("disp_fetch_drop", 32'(pcCnt), 32'h0);
        check("disp_ack_early", 32'(irqAck), 32'h0);
        check("disp_imeclr_early", 32'(imeClear), 32'h0);
        ackQ.push_back(5'h04); pushQ.push_back(8'h12); pushQ.push_back(8'h34);
        busyCnt = 0;
        tick();
        clearInputs();
        check("disp_ack", 32'(irqAck), 32'h04);
        check("disp_imeclr", 32'(imeClear), 32'h1);
        runUntilIdle("disp");
        check("disp_busy_cycles", 32'(busyCnt), 32'd5);
        check("disp_pc", 32'(pc), 32'h0050);
        check("disp_pushq", 32'(pushQ.size()), 32'h0);
        check("disp_ackq", 32'(ackQ.size()), 32'h0);

        // Priority with all sources pending, then a 4-cycle push stall.
        pc = 16'h1234; irqFlags = 5'h1F; irqEnable = 5'h1F; ime = 1; instrBoundary = 1;
        pushReady = 0;
        ackQ.push_back(5'h01); pushQ.push_back(8'h12); pushQ.push_back(8'h34);
        tick();
        clearInputs();
        tick(); tick();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("stall%0d_valid", i), 32'(pushValid), 32'h1);
            check($sformatf("stall%0d_data", i), 32'(pushData), 32'h12);
            tick();
        end
        check("stall_hold_data", 32'(pushData), 32'h12);
        pushReady = 1;
        tick();
        check("prio_lo_data", 32'(pushData), 32'h34);
        tick();
        check("prio_vec_we", 32'(pcWe), 32'h1);
        check("prio_vec_data", 32'(pcData), 32'h0040);
        tick();
        check("prio_pc", 32'(pc), 32'h0040);
        check("prio_idle", 32'(busy), 32'h0);

        // HALT, wake without IME, then wake with IME into JOYPAD.
        pc = 16'h0300; haltReq = 1;
        tick();
        haltReq = 0; fetchReq = 1;
        #1;
        check("halt_halted", 32'(halted), 32'h1);
        check("halt_cnt", 32'(pcCnt), 32'h0);
        tick();
        check("halt_pc", 32'(pc), 32'h0300);
        fetchReq = 0; irqFlags = 5'h10; irqEnable = 5'h10;
        tick();
        check("wake_noime_halted", 32'(halted), 32'h0);
        check("wake_noime_busy", 32'(busy), 32'h0);
        irqFlags = 0;
        tick();
        haltReq = 1;
        tick();
        haltReq = 0;
        check("halt2_halted", 32'(halted), 32'h1);
        ime = 1; irqFlags = 5'h10;
        ackQ.push_back(5'h10); pushQ.push_back(8'h03); pushQ.push_back(8'h00);
        tick();
        clearInputs();
        check("wake_ime_busy", 32'(busy), 32'h1);
        runUntilIdle("wake");
        check("wake_pc", 32'(pc), 32'h0060);
        check("wake_pushq", 32'(pushQ.size()), 32'h0);

        // Reset asserted during PUSH_LO aborts the dispatch.
        pc = 16'h1234; irqFlags = 5'h01; irqEnable = 5'h01; ime = 1; instrBoundary = 1;
        ackQ.push_back(5'h01); pushQ.push_back(8'h12);
        tick();
        clearInputs();
        tick(); tick(); tick();
        check("abort_in_pushlo", 32'(pushData), 32'h34);
        rstN = 0;
        #1;
        check("abort_valid", 32'(pushValid), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_data", 32'(pcData), 32'h0);
        check("abort_we", 32'(pcWe), 32'h0);
        tick();
        rstN = 1;
        tick(); tick();
        check("post_rst_busy", 32'(busy), 32'h0);
        check("post_rst_valid", 32'(pushValid), 32'h0);
        check("post_rst_halted", 32'(halted), 32'h0);
        check("post_rst_pc", 32'(pc), 32'h1234);
        check("final_pushq", 32'(pushQ.size()), 32'h0);
        check("final_ackq", 32'(ackQ.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
